// File: rtl/multicycle_addsub_pkg.sv
// Shared definitions for the chunk-serial adder/subtractor: FSM state encoding
// and a small helper for the chunk-index width.
package multicycle_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index register width; a single chunk still needs a 1-bit register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multicycle_addsub_chunk_adder.sv
// Combinational CHUNK-bit full adder used once per RUN cycle by the top.
module chunk_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/multicycle_addsub.sv
// Add/subtract that processes CHUNK bits per clock through one shared chunk
// adder; result, carry-out and signed overflow are held after the done pulse.
module multicycle_addsub
    import multicycle_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = idx_width(N);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("multicycle_addsub: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q, cout_q, ovf_q, busy_q, done_q;
    logic [IW-1:0]    idx_q;

    int               base;
    logic [CHUNK-1:0] ca, cb, cs;
    logic             cco;

    always_comb begin
        base = int'(idx_q) * CHUNK;
        ca   = a_q[base +: CHUNK];
        cb   = b_q[base +: CHUNK];
    end

    chunk_adder #(.W(CHUNK)) u_chunk (
        .a    (ca),
        .b    (cb),
        .cin  (carry_q),
        .s    (cs),
        .cout (cco)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b once, seed carry with 1.
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= sub;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sum_q[base +: CHUNK] <= cs;
                    carry_q              <= cco;
                    if (idx_q == IW'(N - 1)) begin
                        cout_q  <= cco;
                        ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                   (cs[CHUNK-1] != a_q[WIDTH-1]);
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_multicycle_addsub.sv
// Scoreboard bench: 16/4 instance for directed and random ops, 4/4 instance
// for the exhaustive single-chunk sweep.
module tb_multicycle_addsub;
    import multicycle_addsub_pkg::*;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          t0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start16 = 1'b0, sub16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;
    logic        start4 = 1'b0, sub4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4, cout4, ovf4;
    logic [3:0]  sum4;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t q16[$];
    exp_t q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multicycle_addsub #(.WIDTH(16), .CHUNK(4)) d16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    multicycle_addsub #(.WIDTH(4), .CHUNK(4)) d4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Independent reference: plain unsigned/signed integer arithmetic.
    function automatic exp_t ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                    input logic sub, input int t0);
        exp_t   e;
        longint ua, ub, sa, sb, r, sr, lim;
        ua  = longint'(a);
        ub  = longint'(b);
        lim = longint'(1) << (w - 1);
        sa  = a[w-1] ? ua - (lim << 1) : ua;
        sb  = b[w-1] ? ub - (lim << 1) : ub;
        r   = sub ? ua - ub : ua + ub;
        sr  = sub ? sa - sb : sa + sb;
        e.sum  = 16'(r & ((lim << 1) - 1));
        e.cout = sub ? (ua >= ub) : ((r >> w) & 1) != 0;
        e.ovf  = (sr >= lim) || (sr < -lim);
        e.t0   = t0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done16) begin
            if (q16.size() == 0) chk("spurious_done16", 1, 0);
            else begin
                exp_t e;
                e = q16.pop_front();
                chk("sum16", sum16, e.sum);
                chk("cout16", cout16, e.cout);
                chk("ovf16", ovf16, e.ovf);
                chk("lat16", cyc - e.t0, 4);
                chk("busy_in_done16", busy16, 0);
            end
        end
        if (done4) begin
            if (q4.size() == 0) chk("spurious_done4", 1, 0);
            else begin
                exp_t e;
                e = q4.pop_front();
                chk("sum4", sum4, e.sum);
                chk("cout4", cout4, e.cout);
                chk("ovf4", ovf4, e.ovf);
                chk("lat4", cyc - e.t0, 1);
            end
        end
    end

    // Drive one start at a negedge; accepted on the following posedge.
    task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic s, input bit push);
        @(negedge clk);
        a16 = a; b16 = b; sub16 = s; start16 = 1'b1;
        if (push) q16.push_back(ref_op(16, a, b, s, cyc + 1));
        @(posedge clk);
        #1 start16 = 1'b0;
    endtask

    task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic s);
        @(negedge clk);
        a4 = a; b4 = b; sub4 = s; start4 = 1'b1;
        q4.push_back(ref_op(4, {12'd0, a}, {12'd0, b}, s, cyc + 1));
        @(posedge clk);
        #1 start4 = 1'b0;
    endtask

    task automatic drain16();
        int n = 0;
        while (q16.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q16.size() != 0) chk("timeout16", 1, 0);
        @(negedge clk);
    endtask

    task automatic drain4();
        int n = 0;
        while (q4.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (q4.size() != 0) chk("timeout4", 1, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy16, 0);
        chk("rst_done", done16, 0);
        chk("rst_sum", sum16, 0);
        chk("rst_cout", cout16, 0);
        chk("rst_ovf", ovf16, 0);
        chk("rst_state", d16.state_q, ST_IDLE);
        rst = 1'b0;

        go16(16'h0001, 16'hFFFF, 1'b0, 1);
        chk("busy_run", busy16, 1);
        drain16();
        go16(16'h7FFF, 16'h0001, 1'b0, 1);
        drain16();
        go16(16'h0005, 16'h0007, 1'b1, 1);
        drain16();
        chk("hold_sum", sum16, 16'hFFFE);

        // Start 2 cycles into RUN must be ignored.
        go16(16'h1234, 16'h1111, 1'b0, 1);
        @(negedge clk);
        @(negedge clk);
        a16 = 16'hAAAA; b16 = 16'h5555; sub16 = 1'b1; start16 = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
        chk("busy_ignored", busy16, 1);
        drain16();

        // Start in the DONE cycle goes straight back to RUN.
        go16(16'h8000, 16'h8000, 1'b0, 1);
        begin
            int n = 0;
            while (!done16 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("saw_done", done16, 1);
        end
        a16 = 16'h0100; b16 = 16'h0200; sub16 = 1'b1; start16 = 1'b1;
        q16.push_back(ref_op(16, 16'h0100, 16'h0200, 1'b1, cyc + 1));
        @(posedge clk);
        #1 start16 = 1'b0;
        @(negedge clk);
        chk("busy_after_done_start", busy16, 1);
        drain16();

        // Reset mid-RUN aborts without a done pulse.
        go16(16'h4444, 16'h3333, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy16, 0);
        chk("abort_done", done16, 0);
        chk("abort_sum", sum16, 0);
        chk("abort_cout", cout16, 0);
        chk("abort_ovf", ovf16, 0);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        go16(16'hC000, 16'h4001, 1'b1, 1);
        drain16();

        for (int i = 0; i < 20; i++) begin
            go16(16'($urandom), 16'($urandom), 1'($urandom), 1);
            drain16();
        end

        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++) begin
                    go4(4'(x), 4'(y), 1'(m));
                    drain4();
                end

        repeat (3) @(negedge clk);
        chk("q16_empty", q16.size(), 0);
        chk("q4_empty", q4.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
